// File: rtl/cdc_pkg.sv
// Shared constants, types and helpers for the multi-channel CDC synchroniser/filter.
package cdc_pkg;

    localparam int CDC_MIN_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } filt_state_e;

    // Filter counter width; a one-cycle filter still needs a legal 1-bit counter.
    function automatic int cdc_cnt_w(input int filter_len);
        int w;
        w = $clog2(filter_len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cdc_filter_chan.sv
// One channel: synchroniser chain, glitch filter, edge pulses and optional sticky rise flag.
// Sticky flag is built only when CDC_SYNC_FILTER_STICKY_EN is defined.
module cdc_filter_chan
    import cdc_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 4,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic dest_clk,
    input  logic dest_rst_n,
    input  logic src_in,
    input  logic sticky_clr,
    output logic dest_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic sticky_rise
);

    localparam int              CNT_W  = cdc_cnt_w(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(FILTER_LEN - 1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dest_out_q, dest_out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s_sync;
    filt_state_e            filt_state;

    assign s_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], src_in};
        filt_state = (s_sync != dest_out_q) ? QUAL : IDLE;
        cnt_d      = '0;
        dest_out_d = dest_out_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        case (filt_state)
            QUAL: begin
                if (cnt_q == CNT_TC) begin
                    dest_out_d = s_sync;
                    rise_d     = s_sync;
                    fall_d     = ~s_sync;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge dest_clk) begin
        if (!dest_rst_n) begin
            sync_q     <= {SYNC_STAGES{RESET_VAL}};
            cnt_q      <= '0;
            dest_out_q <= RESET_VAL;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            dest_out_q <= dest_out_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    assign dest_out   = dest_out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef CDC_SYNC_FILTER_STICKY_EN
    logic sticky_q, sticky_d;

    // Set takes priority over a simultaneous clear so no event is lost.
    always_comb begin
        sticky_d = rise_q | (sticky_q & ~sticky_clr);
    end

    always_ff @(posedge dest_clk) begin
        if (!dest_rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_rise = sticky_q;
`else
    logic sticky_clr_unused;
    assign sticky_clr_unused = sticky_clr;
    assign sticky_rise       = 1'b0;
`endif

endmodule

// File: rtl/cdc_sync_filter_array.sv
// WIDTH independent synchronise-and-filter channels for asynchronous status inputs.
// Optional sticky rise flags enabled by CDC_SYNC_FILTER_STICKY_EN.
module cdc_sync_filter_array
    import cdc_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILTER_LEN  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             dest_clk,
    input  logic             dest_rst_n,
    input  logic [WIDTH-1:0] src_in,
    output logic [WIDTH-1:0] dest_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] sticky_rise,
    input  logic [WIDTH-1:0] sticky_clr
);

    if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_chk_sync
        $error("cdc_sync_filter_array: SYNC_STAGES must be >= 2");
    end
    if (FILTER_LEN < 1) begin : g_chk_filt
        $error("cdc_sync_filter_array: FILTER_LEN must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        cdc_filter_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .RESET_VAL   (RESET_VAL[i])
        ) u_chan (
            .dest_clk    (dest_clk),
            .dest_rst_n  (dest_rst_n),
            .src_in      (src_in[i]),
            .sticky_clr  (sticky_clr[i]),
            .dest_out    (dest_out[i]),
            .rise_pulse  (rise_pulse[i]),
            .fall_pulse  (fall_pulse[i]),
            .sticky_rise (sticky_rise[i])
        );
    end

endmodule

// File: tb/tb_cdc_sync_filter_array.sv
// Bench for cdc_sync_filter_array: two configurations driven in parallel and checked
// against a window-based reference model, plus directed latency/glitch/reset/sticky cases.
module tb_cdc_sync_filter_array;

    logic       dest_clk   = 1'b0;
    logic       dest_rst_n = 1'b0;
    logic [3:0] src_in     = 4'h0;
    logic [3:0] sticky_clr = 4'h0;
    logic [3:0] out1, r1, f1, st1;
    logic [3:0] out2, r2, f2, st2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 dest_clk = ~dest_clk;

    cdc_sync_filter_array #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_LEN(4), .RESET_VAL(4'b0000)) dut1 (
        .dest_clk(dest_clk), .dest_rst_n(dest_rst_n), .src_in(src_in),
        .dest_out(out1), .rise_pulse(r1), .fall_pulse(f1),
        .sticky_rise(st1), .sticky_clr(sticky_clr));

    cdc_sync_filter_array #(.WIDTH(4), .SYNC_STAGES(3), .FILTER_LEN(1), .RESET_VAL(4'b0000)) dut2 (
        .dest_clk(dest_clk), .dest_rst_n(dest_rst_n), .src_in(src_in),
        .dest_out(out2), .rise_pulse(r2), .fall_pulse(f2),
        .sticky_rise(st2), .sticky_clr(sticky_clr));

    // Reference model: per config c, per channel i.
    logic pipe_m [2][4][3];
    logic win_m  [2][4][4];
    int   wlen_m [2][4];
    logic out_m  [2][4];
    logic rise_m [2][4];
    logic fall_m [2][4];
    logic st_m   [2][4];

    function automatic int ss_of(input int c);
        return (c == 0) ? 2 : 3;
    endfunction

    function automatic int fl_of(input int c);
        return (c == 0) ? 4 : 1;
    endfunction

    task automatic model_step();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!dest_rst_n) begin
                    for (int j = 0; j < 3; j++) pipe_m[c][i][j] = 1'b0;
                    wlen_m[c][i] = 0;
                    out_m[c][i]  = 1'b0;
                    rise_m[c][i] = 1'b0;
                    fall_m[c][i] = 1'b0;
                    st_m[c][i]   = 1'b0;
                end else begin
                    logic s, flip;
                    s = pipe_m[c][i][ss_of(c)-1];
                    for (int j = 3; j > 0; j--) win_m[c][i][j] = win_m[c][i][j-1];
                    win_m[c][i][0] = s;
                    if (wlen_m[c][i] < 4) wlen_m[c][i]++;
                    // Flip only when the last FILTER_LEN synchronised samples all disagree with the output.
                    flip = (wlen_m[c][i] >= fl_of(c));
                    for (int j = 0; j < fl_of(c); j++)
                        if (win_m[c][i][j] == out_m[c][i]) flip = 1'b0;
`ifdef CDC_SYNC_FILTER_STICKY_EN
                    st_m[c][i] = rise_m[c][i] | (st_m[c][i] & ~sticky_clr[i]);
`else
                    st_m[c][i] = 1'b0;
`endif
                    rise_m[c][i] = flip & ~out_m[c][i];
                    fall_m[c][i] = flip &  out_m[c][i];
                    if (flip) out_m[c][i] = ~out_m[c][i];
                    for (int j = ss_of(c) - 1; j > 0; j--) pipe_m[c][i][j] = pipe_m[c][i][j-1];
                    pipe_m[c][i][0] = src_in[i];
                end
            end
        end
    endtask

    function automatic logic [3:0] mvec(input int c, input int k);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) begin
            case (k)
                0:       v[i] = out_m[c][i];
                1:       v[i] = rise_m[c][i];
                2:       v[i] = fall_m[c][i];
                default: v[i] = st_m[c][i];
            endcase
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge dest_clk);
        model_step();
        #1;
        check("m1_out",  out1, mvec(0, 0));
        check("m1_rise", r1,   mvec(0, 1));
        check("m1_fall", f1,   mvec(0, 2));
        check("m1_stk",  st1,  mvec(0, 3));
        check("m2_out",  out2, mvec(1, 0));
        check("m2_rise", r2,   mvec(1, 1));
        check("m2_fall", f2,   mvec(1, 2));
        check("m2_stk",  st2,  mvec(1, 3));
        check("excl1",   r1 & f1, 4'h0);
        check("excl2",   r2 & f2, 4'h0);
    endtask

    task automatic lat_test(input int ch, input logic v);
        src_in[ch] = v;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("lat_out",  {3'b0, out1[ch]}, {3'b0, (k >= 6) ? v : ~v});
            check("lat_rise", {3'b0, r1[ch]},   {3'b0, (k == 6) &  v});
            check("lat_fall", {3'b0, f1[ch]},   {3'b0, (k == 6) & ~v});
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic [3:0] src;
        logic [3:0] exp_out;
        logic [3:0] exp_rise;
        logic [3:0] exp_fall;
    } vec_t;

    initial begin
        vec_t tbl[$];
        logic hist[$];
        int   j;

        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 3; k++) pipe_m[c][i][k] = 1'b0;
                for (int k = 0; k < 4; k++) win_m[c][i][k] = 1'b0;
                wlen_m[c][i] = 0;
                out_m[c][i] = 1'b0; rise_m[c][i] = 1'b0;
                fall_m[c][i] = 1'b0; st_m[c][i] = 1'b0;
            end

        // Reset with inputs high, then release: output rises on the sixth edge after release.
        for (int k = 0; k < 3; k++) tbl.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 4'h0});
        for (int k = 0; k < 5; k++) tbl.push_back('{1'b1, 4'hF, 4'h0, 4'h0, 4'h0});
        tbl.push_back('{1'b1, 4'hF, 4'hF, 4'hF, 4'h0});
        for (int k = 0; k < 2; k++) tbl.push_back('{1'b1, 4'hF, 4'hF, 4'h0, 4'h0});
        for (int k = 0; k < tbl.size(); k++) begin
            dest_rst_n = tbl[k].rst_n;
            src_in     = tbl[k].src;
            tick();
            check("tbl_out",  out1, tbl[k].exp_out);
            check("tbl_rise", r1,   tbl[k].exp_rise);
            check("tbl_fall", f1,   tbl[k].exp_fall);
            check("tbl_stk",  st1,  4'h0);
        end

        src_in = 4'h0;
        for (int k = 0; k < 8; k++) tick();
        check("all_low", out1, 4'h0);

        lat_test(0, 1'b1);
        lat_test(0, 1'b0);

        // Three-cycle glitch on channel 1 is swallowed.
        src_in[1] = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        src_in[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("glitch", {out1[1], r1[1], f1[1]}, 4'h0);
        end

        // Reset while channel 2 is two counts into qualification.
        src_in[2] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("midq_cnt", {2'b0, dut1.g_chan[2].u_chan.cnt_q}, 4'd2);
        dest_rst_n = 1'b0;
        src_in[2]  = 1'b0;
        tick();
        check("midq_rst_cnt", {2'b0, dut1.g_chan[2].u_chan.cnt_q}, 4'd0);
        dest_rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("midq_after", {out1[2], r1[2], f1[2]}, 4'h0);
        end

        // Sticky flag on channel 3: clear held while the rise pulse is visible.
        src_in[3] = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check("stk_pulse", r1, 4'h8);
        sticky_clr[3] = 1'b1;
        tick();
`ifdef CDC_SYNC_FILTER_STICKY_EN
        check("stk_set_wins", st1, 4'h8);
`else
        check("stk_set_wins", st1, 4'h0);
`endif
        tick();
        check("stk_cleared", st1, 4'h0);
        sticky_clr = 4'h0;
        tick();

        // Toggle channel 0 every two cycles; the 3-stage/no-filter instance tracks with 3 edges of latency.
        for (j = 0; j < 30; j++) begin
            src_in[0] = ((j / 2) % 2) == 1;
            hist.push_back(src_in[0]);
            tick();
            if (j >= 4) begin
                check("tog_out",  {3'b0, out2[0]}, {3'b0, hist[j-3]});
                check("tog_rise", {3'b0, r2[0]},   {3'b0, hist[j-3] & ~hist[j-4]});
                check("tog_fall", {3'b0, f2[0]},   {3'b0, ~hist[j-3] & hist[j-4]});
                check("tog_slow", {3'b0, r1[0] | f1[0]}, 4'h0);
            end
        end

        // Random phase: sparse input changes, random clears, occasional reset.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) src_in[i] = ~src_in[i];
            sticky_clr = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            dest_rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
